// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, muldiv request encodings and sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_MUL = 4'd5;
  localparam logic [3:0] ALU_DIV = 4'd6;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam int unsigned N_ITER    = 32;
  localparam logic [5:0]  LAST_ITER = 6'(N_ITER - 1);

  // state | meaning
  // IDLE  | ready for a request
  // MUL   | shift-add iteration through the ALU
  // DIV   | restoring-divide iteration through the ALU
  // DONE  | result held until the consumer takes it
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/DIVU/REMU sequencer that borrows the core ALU for its
// ADD/SUB steps; the ALU itself lives outside and is muxed in while alu_own is high.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;

  logic              req_is_div;
  logic              last_iter;
  logic [XLEN-1:0]   sh;
  logic              ge;

  assign req_is_div = (req_op == OP_DIVU) || (req_op == OP_REMU);
  assign last_iter  = (cnt_q == LAST_ITER);
  assign sh         = {acc_q[XLEN-2:0], opb_q[XLEN-1]};
  // acc_q[31] stands in for the 33rd bit of the shifted remainder.
  assign ge         = acc_q[XLEN-1] | (sh >= div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        if (!req_is_div)      state_d = ST_MUL;
        else if (req_b == '0) state_d = ST_DONE;
        else                  state_d = ST_DIV;
      end
      ST_MUL:  if (last_iter) state_d = ST_DONE;
      ST_DIV:  if (last_iter) state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        op_d  = req_op;
        acc_d = '0;
        cnt_d = '0;
        if (!req_is_div) begin
          opa_d = req_a;
          opb_d = req_b;
        end else if (req_b == '0) begin
          opb_d = '1;
          acc_d = req_a;
        end else begin
          opb_d = req_a;
          div_d = req_b;
        end
      end
      ST_MUL: begin
        if (opb_q[0]) acc_d = alu_result;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + 6'd1;
      end
      ST_DIV: begin
        acc_d = ge ? alu_result : sh;
        opb_d = {opb_q[XLEN-2:0], ge};
        cnt_d = cnt_q + 6'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_DONE);
    rsp_data  = '0;
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_ADD;
    unique case (state_q)
      ST_MUL: begin
        alu_own  = 1'b1;
        alu_a    = acc_q;
        alu_b    = opa_q;
        alu_ctrl = ALU_ADD;
      end
      ST_DIV: begin
        alu_own  = 1'b1;
        alu_a    = sh;
        alu_b    = div_q;
        alu_ctrl = ALU_SUB;
      end
      ST_DONE: rsp_data = (op_q == OP_DIVU) ? opb_q : acc_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboarded bench for alu_muldiv_seq with a behavioural ADD/SUB ALU beside it.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign alu_result = (alu_ctrl == 4'd1) ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return p[31:0];
    endcase
  endfunction

  // Returns after the accept edge (+1) with the expectation queued.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%0b required 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts cycles from accept to first visible rsp_valid, compares and consumes the result.
  task automatic collect(input string name, input int exp_lat, input int exp_own);
    int k = 0, own = 0;
    logic [31:0] exp;
    do begin
      @(negedge clk);
      k++;
      if (alu_own) own++;
    end while (!rsp_valid && k < 100);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s_timeout: rsp_valid=%0b required 1 within 100 cycles", name, rsp_valid);
    end
    checks++;
    if (rsp_data !== exp) begin
      errors++;
      $display("FAIL %s_data: got %08h required %08h", name, rsp_data, exp);
    end
    checks++;
    if (k != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, k, exp_lat);
    end
    checks++;
    if (own != exp_own) begin
      errors++;
      $display("FAIL %s_alu_own: got %0d cycles required %0d", name, own, exp_own);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic txn(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    int lat;
    lat = ((op == 2'b01 || op == 2'b10) && b == 0) ? 1 : 33;
    issue(op, a, b);
    collect(name, lat, (lat == 1) ? 0 : 32);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || alu_own !== 1'b0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin
      errors++;
      $display("FAIL %s: rr=%0b rv=%0b rd=%08h own=%0b a=%08h b=%08h c=%0d required 1 0 0 0 0 0 0",
               name, req_ready, rsp_valid, rsp_data, alu_own, alu_a, alu_b, alu_ctrl);
    end
  endtask

  task automatic test_reset();
    #1 check_reset_outputs("reset_values");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check_reset_outputs("after_release");
  endtask

  task automatic test_mul();
    txn("mul_7x6", 2'b00, 32'd7, 32'd6);
    txn("mul_wrap_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    txn("mul_wrap_msb", 2'b00, 32'h8000_0000, 32'd2);
    txn("mul_reserved_op", 2'b11, 32'h0001_2345, 32'h0000_0F0F);
  endtask

  task automatic test_div();
    txn("divu_100_7", 2'b01, 32'd100, 32'd7);
    txn("remu_100_7", 2'b10, 32'd100, 32'd7);
    txn("divu_5_9", 2'b01, 32'd5, 32'd9);
    txn("remu_5_9", 2'b10, 32'd5, 32'd9);
    txn("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000);
    txn("remu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0000);
    txn("divu_fe_ff", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    txn("remu_fe_ff", 2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 0) b = 32'd3;
      txn("divu_rand", 2'b01, a, b);
      txn("remu_rand", 2'b10, a, b);
    end
  endtask

  task automatic test_div_zero();
    txn("divu_zero", 2'b01, 32'h1234, 32'd0);
    txn("remu_zero", 2'b10, 32'h1234, 32'd0);
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic [31:0] exp;
    issue(2'b00, 32'd1000, 32'd3000);
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 100);
    exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== exp) begin
        errors++;
        $display("FAIL backpressure_hold: rv=%0b rr=%0b rd=%08h required 1 0 %08h",
                 rsp_valid, req_ready, rsp_data, exp);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: rr=%0b rv=%0b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    txn("b2b_0", 2'b00, 32'd12345, 32'd678);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap: req_ready=%0b required 1", req_ready);
    end
    txn("b2b_1", 2'b01, 32'd98765, 32'd43);
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    issue(2'b00, 32'd7, 32'd6);
    void'(exp_q.pop_back());
    repeat (15) @(negedge clk);
    checks++;
    if (alu_own !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy: alu_own=%0b required 1", alu_own);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midop_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midop_no_rsp: rsp_valid cycles=%0d required 0", seen);
    end
    txn("after_reset_mul", 2'b00, 32'd7, 32'd6);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
